// File: rtl/tns_encoder_seq.sv
// tns_encoder_seq
// Multi-cycle TNS encoder. Takes one DLEN-bit word and produces a 3*NGROUP-bit
// TNS codeword, resolving one {A,B,C} group per clock, MSB group first.
// A per-group history bit (prev) resolves A-bits whose value is ambiguous, so
// consecutive codewords toggle as few A lines as possible.
//
// Build option:
//   TNS_SEQ_RANGE_CHECK_EN  adds the err output. A word >= CAP skips encoding
//                           and is returned as codeout=0 with err=1.
//
// Parameters:
//   NGROUP   number of 3-bit groups (codeout width 3*NGROUP)
//   DLEN     data width and weight width
//   WEIGHTS  packed table; A(g) at slot 3g+2, B(g) at 3g+1, C(g) at 3g
//   CAP      count of representable values; legal input 0..CAP-1
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   datain is valid
//   in_ready   a word can be accepted this cycle
//   datain     word to encode
//   out_valid  codeout is valid (held until out_ready)
//   out_ready  sink accepts codeout
//   codeout    TNS codeword
//   busy       encoder is not idle
//   err        out-of-range flag, valid with out_valid (range-check build only)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a word; in_ready=1
// ENC   | resolving group gcnt, one group per cycle, MSB group first
// DONE  | out_valid=1, codeout stable; may accept the next word directly

`ifndef TNS_W09
`define TNS_W09 {16'd13122, 16'd6561, 16'd6561, \
                 16'd4374,  16'd2187, 16'd2187, \
                 16'd1458,  16'd729,  16'd729,  \
                 16'd486,   16'd243,  16'd243,  \
                 16'd162,   16'd81,   16'd81,   \
                 16'd54,    16'd27,   16'd27,   \
                 16'd18,    16'd9,    16'd9,    \
                 16'd6,     16'd3,    16'd3,    \
                 16'd2,     16'd1,    16'd1}
`endif

`ifndef TNS_CAP09
`define TNS_CAP09 29524
`endif

module tns_encoder_seq #(
    parameter int unsigned               NGROUP  = 9,
    parameter int unsigned               DLEN    = 16,
    parameter logic [NGROUP*3*DLEN-1:0]  WEIGHTS = `TNS_W09,
    parameter int unsigned               CAP     = `TNS_CAP09
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DLEN-1:0]       datain,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3*NGROUP-1:0]   codeout,
    output logic                  busy
`ifdef TNS_SEQ_RANGE_CHECK_EN
    ,
    output logic                  err
`endif
);

    localparam int unsigned GW = (NGROUP > 1) ? $clog2(NGROUP) : 1;

    // Catch a table that cannot be encoded at elaboration time.
    if (NGROUP == 0 || CAP == 0 || 64'(CAP) > (64'(1) << DLEN)) begin : g_bad_param
        $error("tns_encoder_seq: illegal NGROUP/CAP for this DLEN");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [GW-1:0]      gcnt;
    logic [DLEN-1:0]    resid;
    logic [NGROUP-1:0]  prev;

    // Unpack the weight table once so the group step can index by gcnt.
    logic [DLEN-1:0] w_a [NGROUP];
    logic [DLEN-1:0] w_b [NGROUP];
    logic [DLEN-1:0] w_c [NGROUP];

    for (genvar g = 0; g < NGROUP; g++) begin : g_weights
        assign w_a[g] = WEIGHTS[(3*g+2)*DLEN +: DLEN];
        assign w_b[g] = WEIGHTS[(3*g+1)*DLEN +: DLEN];
        assign w_c[g] = WEIGHTS[(3*g)*DLEN   +: DLEN];
    end

    logic              accept;
    logic [DLEN-1:0]   cur_a;
    logic [DLEN-1:0]   cur_b;
    logic [DLEN-1:0]   cur_c;
    logic [DLEN:0]     sum_ac;
    logic [DLEN-1:0]   r1;
    logic [DLEN-1:0]   r2;
    logic [DLEN-1:0]   resid_next;
    logic              bit_a;
    logic              bit_b;
    logic              bit_c;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

`ifdef TNS_SEQ_RANGE_CHECK_EN
    localparam logic [DLEN:0] CAP_EXT = (DLEN+1)'(CAP);
    logic out_of_range;
    assign out_of_range = ({1'b0, datain} >= CAP_EXT);
`endif

    // One group step on the current residual.
    always_comb begin
        cur_a  = w_a[gcnt];
        cur_b  = w_b[gcnt];
        cur_c  = w_c[gcnt];
        // A+C can exceed DLEN bits, so compare one bit wider.
        sum_ac = {1'b0, cur_a} + {1'b0, cur_c};

        // Between A and A+C-1 the residual can be coded either way;
        // reuse last word's A-bit for this group to avoid a toggle.
        if (resid < cur_a) begin
            bit_a = 1'b0;
        end else if ({1'b0, resid} >= sum_ac) begin
            bit_a = 1'b1;
        end else begin
            bit_a = prev[gcnt];
        end

        r1    = bit_a ? (resid - cur_a) : resid;
        bit_b = (r1 >= cur_b);
        r2    = bit_b ? (r1 - cur_b) : r1;

        // The last group takes whatever unit is left as its C-bit.
        if (gcnt == '0) begin
            bit_c      = r2[0];
            resid_next = r2;
        end else begin
            bit_c      = (r2 >= cur_c);
            resid_next = bit_c ? (r2 - cur_c) : r2;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gcnt      <= '0;
            resid     <= '0;
            prev      <= '0;
            codeout   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef TNS_SEQ_RANGE_CHECK_EN
            err       <= 1'b0;
`endif
        end else if (accept) begin
            // Accept happens from IDLE or, back-to-back, from DONE.
            resid     <= datain;
            gcnt      <= GW'(NGROUP - 1);
            out_valid <= 1'b0;
            busy      <= 1'b1;
            state     <= ENC;
`ifdef TNS_SEQ_RANGE_CHECK_EN
            err       <= 1'b0;
            if (out_of_range) begin
                codeout   <= '0;
                err       <= 1'b1;
                out_valid <= 1'b1;
                state     <= DONE;
            end
`endif
        end else begin
            case (state)
                ENC: begin
                    resid <= resid_next;
                    for (int g = 0; g < NGROUP; g++) begin
                        if (int'(gcnt) == g) begin
                            codeout[3*g +: 3] <= {bit_a, bit_b, bit_c};
                            prev[g]           <= bit_a;
                        end
                    end
                    if (gcnt == '0) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        gcnt <= gcnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tns_encoder_seq.sv
// Testbench for tns_encoder_seq with NGROUP=2, DLEN=4,
// weights g1 = 6,3,3 and g0 = 2,1,1, CAP=13.
module tb_tns_encoder_seq;

    localparam int unsigned NG = 2;
    localparam int unsigned DL = 4;
    localparam logic [23:0] W  = {4'd6, 4'd3, 4'd3, 4'd2, 4'd1, 4'd1};

    logic       clock     = 1'b0;
    logic       reset     = 1'b1;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b1;
    logic [3:0] datain    = '0;
    logic       in_ready;
    logic       out_valid;
    logic       busy;
    logic [5:0] codeout;
`ifdef TNS_SEQ_RANGE_CHECK_EN
    logic       err;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [5:0] code;
        logic       err;
    } exp_t;

    exp_t sb[$];

    tns_encoder_seq #(
        .NGROUP  (NG),
        .DLEN    (DL),
        .WEIGHTS (W),
        .CAP     (13)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .datain    (datain),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .codeout   (codeout),
        .busy      (busy)
`ifdef TNS_SEQ_RANGE_CHECK_EN
        ,
        .err       (err)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Monitor: pop and compare on every output handshake.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            exp_t e;
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: codeout %b with empty scoreboard", codeout);
            end else begin
                e = sb.pop_front();
                check("codeout", 32'(codeout), 32'(e.code));
`ifdef TNS_SEQ_RANGE_CHECK_EN
                check("err", 32'(err), 32'(e.err));
`endif
            end
        end
    end

    task automatic push_exp(input logic [5:0] code, input logic e);
        exp_t x;
        x.code = code;
        x.err  = e;
        sb.push_back(x);
    endtask

    // Offer one word from IDLE, then check latency to out_valid.
    task automatic send(input logic [3:0] d, input logic [5:0] code, input logic e,
                        input int lat, input string nm);
        int  n;
        bit  got;
        @(posedge clock); #1;
        in_valid = 1'b1;
        datain   = d;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (in_ready) got = 1'b1;
        end
        check({nm, "_accept"}, 32'(got), 32'd1);
        if (!got) begin
            in_valid = 1'b0;
            return;
        end
        push_exp(code, e);
        @(posedge clock); #1;
        in_valid = 1'b0;
        datain   = '0;
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (out_valid) got = 1'b1;
            else begin
                n++;
                check({nm, "_busy_enc"}, {busy, in_ready}, 32'b10);
            end
        end
        check({nm, "_latency"}, got ? 32'(n) : 32'hFFFF_FFFF, 32'(lat));
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clock);
        check({nm, "_drain"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  got;

        // Reset state, while asserted and after release.
        repeat (2) @(negedge clock);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_codeout",   32'(codeout),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
`ifdef TNS_SEQ_RANGE_CHECK_EN
        check("rst_err",       32'(err),       32'd0);
`endif
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_busy",     32'(busy),     32'd0);

        // Single words; prev history drives the ambiguous A-bit.
        send(4'd7,  6'b011010, 1'b0, 2, "w7_a");
        send(4'd7,  6'b011010, 1'b0, 2, "w7_b");
        send(4'd10, 6'b110010, 1'b0, 2, "w10");
        send(4'd11, 6'b110011, 1'b0, 2, "w11");
        send(4'd7,  6'b100010, 1'b0, 2, "w7_hist");
        drain("single");

        // Back-to-back: one accept every 3 cycles, in_ready high in DONE.
        @(posedge clock); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        datain    = 4'd0;
        push_exp(6'b000000, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (in_ready) got = 1'b1;
        end
        check("b2b_first_accept", 32'(got), 32'd1);
        for (int w = 0; w < 2; w++) begin
            @(posedge clock); #1;
            if (w == 0) begin
                datain = 4'd12;
                push_exp(6'b111000, 1'b0);
            end else begin
                datain = 4'd5;
                push_exp(6'b010011, 1'b0);
            end
            n   = 0;
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clock);
                n++;
                if (in_ready) got = 1'b1;
            end
            check("b2b_period",         got ? 32'(n) : 32'hFFFF_FFFF, 32'd3);
            check("b2b_done_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        drain("b2b");

        // Back-pressure: DONE held for 5 cycles with a word waiting.
        @(posedge clock); #1;
        out_ready = 1'b0;
        send(4'd12, 6'b111000, 1'b0, 2, "hold_word");
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            in_valid = 1'b1;
            datain   = 4'd3;
            @(negedge clock);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_codeout",   32'(codeout),   32'b111000);
            check("hold_in_ready",  32'(in_ready),  32'd0);
            check("hold_busy",      32'(busy),      32'd1);
        end
        @(posedge clock); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        @(posedge clock); #1;
        @(negedge clock);
        check("hold_release_valid", 32'(out_valid), 32'd0);
        check("hold_release_busy",  32'(busy),      32'd0);
        drain("hold");

        // Reset during ENC aborts the word and clears history.
        @(posedge clock); #1;
        in_valid = 1'b1;
        datain   = 4'd7;
        @(negedge clock);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        check("abort_busy_enc", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_codeout",   32'(codeout),   32'd0);
        check("abort_busy",      32'(busy),      32'd0);
        check("abort_in_ready2", 32'(in_ready),  32'd1);
        @(posedge clock); #1;
        reset = 1'b0;
        send(4'd7, 6'b011010, 1'b0, 2, "after_abort");
        drain("abort");

`ifdef TNS_SEQ_RANGE_CHECK_EN
        // Out-of-range word: immediate DONE, codeout=0, err=1, prev kept.
        send(4'd10, 6'b110010, 1'b0, 2, "pre_range");
        send(4'd15, 6'b000000, 1'b1, 0, "range");
        send(4'd7,  6'b100010, 1'b0, 2, "post_range");
        drain("range");
`endif

        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
